// File: rtl/alu_pkg.sv
// Shared ALU opcode/arbiter-state types and the supported-opcode predicate,
// used by the decoder and by alu_arbiter.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_SUB  = 4'b0110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  // Recognisable marker value returned for unsupported opcodes.
  localparam logic [31:0] ALU_BAD_RESULT = 32'h0000_CAFE;

  function automatic logic alu_op_valid(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SLTU, ALU_SUB: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: AND, OR, ADD, SLTU, SUB; any other opcode
// yields ALU_BAD_RESULT.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = ALU_BAD_RESULT;
    case (control)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SLTU: result = {31'b0, (a < b)};
      ALU_SUB:  result = a - b;
      default:  result = ALU_BAD_RESULT;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request found
// searching upward from last+1 (with wrap) wins.
module rr_arbiter #(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  int  idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin grant, one op in flight,
// registered tagged response. Optional per-requester grant counters under
// the macro ALU_ARB_PERF_EN (grant_cnt reads as 0 when undefined).
//
// Handshakes: a transfer happens on a channel in every cycle where its valid
// and ready are both 1 at the rising edge; valid never depends on ready, and a
// requester may withdraw valid before a transfer without side effects.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [4*N_REQ-1:0]    req_control,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic [32*N_REQ-1:0]   grant_cnt
);

  arb_state_e        state, state_d;
  logic [ID_W-1:0]   last;
  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_id;
  logic              hs;
  logic [3:0]        op_control;
  logic [31:0]       op_a, op_b;
  logic [ID_W-1:0]   op_id;
  logic [31:0]       alu_result;
  logic              alu_zero;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req      (req_valid),
    .last     (last),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  alu u_alu (
    .control (op_control),
    .a       (op_a),
    .b       (op_b),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = arb_grant & {N_REQ{rst_n}};
        if (|req_ready) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hs        = |(req_valid & req_ready);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= ID_W'(N_REQ - 1);
      op_control <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_d;
      if (hs) begin
        op_control <= req_control[4*int'(arb_id) +: 4];
        op_a       <= req_a[32*int'(arb_id) +: 32];
        op_b       <= req_b[32*int'(arb_id) +: 32];
        op_id      <= arb_id;
        last       <= arb_id;
      end
      if (state == EXEC) begin
        rsp_id     <= op_id;
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= !alu_op_valid(op_control);
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
      if (!rst_n)                          cnt <= '0;
      else if (req_valid[i] && req_ready[i]) cnt <= cnt + 32'd1;
    end
    assign grant_cnt[32*i +: 32] = cnt;
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (N_REQ=3): directed scenarios plus
// randomized traffic, checked every cycle against a queue-based reference model.
module tb_alu_arbiter;

  localparam int N  = 3;
  localparam int IW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_control;
  logic [32*N-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_zero, rsp_err;
  logic [32*N-1:0] grant_cnt;

  alu_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_control (req_control),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_err     (rsp_err),
    .grant_cnt   (grant_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0110: return a - b;
      default: return 32'h0000_CAFE;
    endcase
  endfunction

  function automatic logic model_err(input logic [3:0] c);
    return !(c == 4'b0000 || c == 4'b0001 || c == 4'b0010 || c == 4'b0011 || c == 4'b0110);
  endfunction

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   res;
    logic          zero;
    logic          err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          age;
  int          m_last;
  logic [31:0] m_cnt [N];
  bit          model_on = 1'b0;
  int          grant_log[$];

  // Compare, then advance the model with the inputs the next edge will sample.
  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    logic         e_valid;
    int           w;
    int           idx;
    rsp_t         e;
    e_ready = '0;
    w       = -1;
    if (rst_n && exp_q.size() == 0) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    if (w >= 0) e_ready[w] = 1'b1;
    e_valid = (exp_q.size() != 0) && (age >= 2);

    if (model_on) begin
      check("req_ready", 64'(req_ready), 64'(e_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(e_valid));
      if (e_valid) begin
        check("rsp_id",     64'(rsp_id),     64'(exp_q[0].id));
        check("rsp_result", 64'(rsp_result), 64'(exp_q[0].res));
        check("rsp_zero",   64'(rsp_zero),   64'(exp_q[0].zero));
        check("rsp_err",    64'(rsp_err),    64'(exp_q[0].err));
      end
      for (int i = 0; i < N; i++) begin
`ifdef ALU_ARB_PERF_EN
        check("grant_cnt", 64'(grant_cnt[32*i +: 32]), 64'(m_cnt[i]));
`else
        check("grant_cnt", 64'(grant_cnt[32*i +: 32]), 64'd0);
`endif
      end
    end

    if (!rst_n) begin
      exp_q.delete();
      age      = 0;
      m_last   = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (e_valid && rsp_ready) void'(exp_q.pop_front());
      else if (exp_q.size() != 0) age++;
      if (w >= 0) begin
        e.id   = IW'(w);
        e.res  = model_alu(req_control[4*w +: 4], req_a[32*w +: 32], req_b[32*w +: 32]);
        e.zero = (e.res == 32'd0);
        e.err  = model_err(req_control[4*w +: 4]);
        exp_q.push_back(e);
        age    = 1;
        m_last = w;
        m_cnt[w]++;
        grant_log.push_back(w);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_control[4*i +: 4] = c;
    req_a[32*i +: 32]     = a;
    req_b[32*i +: 32]     = b;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    rsp_ready = 1'b0;
  endtask

  // One op from requester i with hand-computed expectations; the response is
  // held for 'hold' extra cycles under backpressure while everyone is valid.
  task automatic run_op(input string name, input int i, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_res, input logic e_zero, input logic e_err,
                        input int hold);
    bit got;
    req_valid    = '0;
    rsp_ready    = 1'b0;
    set_req(i, c, a, b);
    req_valid[i] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
      tick();
      if (got) break;
    end
    req_valid = '0;
    check({name, "_handshake"}, 64'(got), 64'd1);
    @(negedge clk);
    check({name, "_lat_t1"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check({name, "_lat_t2"}, 64'(rsp_valid), 64'd1);
    check({name, "_id"},     64'(rsp_id),     64'(i));
    check({name, "_result"}, 64'(rsp_result), 64'(e_res));
    check({name, "_zero"},   64'(rsp_zero),   64'(e_zero));
    check({name, "_err"},    64'(rsp_err),    64'(e_err));
    for (int h = 0; h < hold; h++) begin
      tick();
      req_valid = '1;
      @(negedge clk);
      check({name, "_hold_valid"},  64'(rsp_valid),  64'd1);
      check({name, "_hold_result"}, 64'(rsp_result), 64'(e_res));
      check({name, "_hold_zero"},   64'(rsp_zero),   64'(e_zero));
      check({name, "_hold_ready"},  64'(req_ready),  64'd0);
    end
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check({name, "_accepted"}, 64'(rsp_valid), 64'd0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  localparam logic [3:0] CTRL_TAB [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0101, 4'b1111};

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    rsp_ready   = 1'b0;
    req_control = '0;
    req_a       = '0;
    req_b       = '0;

    // Reset held with every requester valid; then round-robin order.
    req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, 4'b0010, 32'(i), 32'd1);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_grant_cnt", 64'(grant_cnt), 64'd0);
      check("reset_rsp_result", 64'(rsp_result), 64'd0);
      tick();
    end
    grant_log.delete();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (20) tick();
    check("rr_count", 64'(grant_log.size() >= 6), 64'd1);
    for (int k = 0; k < 6; k++)
      check("rr_order", 64'((k < grant_log.size()) ? grant_log[k] : -1), 64'(k % 3));
    drain();

    run_op("add_ovf",   1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 0);
    run_op("sub_bp",    0, 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 4);
    drain();
    run_op("bad_op",    2, 4'b0101, 32'h1234, 32'h5678, 32'h0000_CAFE, 1'b0, 1'b1, 0);
    drain();
    run_op("sltu_edge", 1, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 0);
    drain();
    run_op("sub_wrap",  2, 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    drain();
    run_op("and_op",    0, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 0);
    drain();

    // Reset while the op is executing: it must vanish.
    begin
      bit got;
      set_req(0, 4'b0010, 32'd3, 32'd4);
      req_valid[0] = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (req_ready[0]) got = 1'b1;
        tick();
        if (got) break;
      end
      check("midreset_handshake", 64'(got), 64'd1);
      req_valid = '0;
      rst_n     = 1'b0;
      tick();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midreset_grant_cnt", 64'(grant_cnt), 64'd0);
        tick();
      end
    end

    // Randomized traffic, occasional reset.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        set_req(i, CTRL_TAB[$urandom_range(0, 6)], rand_operand(), rand_operand());
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
